// File: rtl/cmos_pkg.sv
// Shared definitions for the CMOS DVP capture path: FSM encoding, default
// geometry and the RGB565 field layout seen by downstream consumers.
package cmos_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    SKIP       = 2'd1,
    WAIT_FRAME = 2'd2,
    CAPTURE    = 2'd3
  } cap_state_t;

  localparam int DEF_H_ACTIVE   = 640;
  localparam int DEF_V_ACTIVE   = 480;
  localparam int DEF_FRAME_SKIP = 10;
  localparam int LINE_CNT_W     = 11;

  // RGB565 layout: r = [15:11], g = [10:5], b = [4:0].
  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  function automatic logic [15:0] pack_pixel(input logic [7:0] first,
                                             input logic [7:0] second,
                                             input bit         hi_first);
    return hi_first ? {first, second} : {second, first};
  endfunction

endpackage

// File: rtl/cmos_edge_sync.sv
// Registers the sensor vsync/href once, keeps a second stage and derives
// single-cycle edge pulses from the two stages.
module cmos_edge_sync (
  input  logic p_clk,
  input  logic sysrst_n,
  input  logic cmos_vsync,
  input  logic cmos_href,
  output logic v_q,
  output logic h_q,
  output logic v_rise,
  output logic v_fall,
  output logic h_fall
);

  logic v_qq;
  logic h_qq;

  always_ff @(posedge p_clk or negedge sysrst_n) begin
    if (!sysrst_n) begin
      v_q  <= 1'b0;
      v_qq <= 1'b0;
      h_q  <= 1'b0;
      h_qq <= 1'b0;
    end else begin
      v_q  <= cmos_vsync;
      v_qq <= v_q;
      h_q  <= cmos_href;
      h_qq <= h_q;
    end
  end

  assign v_rise = v_q & ~v_qq;
  assign v_fall = ~v_q & v_qq;
  assign h_fall = ~h_q & h_qq;

endmodule

// File: rtl/cmos_capture.sv
// DVP byte-pair to RGB565 packer with start-up frame skipping, frame-done
// level for the BRAM writer and per-frame geometry checking.
module cmos_capture
  import cmos_pkg::*;
#(
  parameter int H_ACTIVE            = DEF_H_ACTIVE,
  parameter int V_ACTIVE            = DEF_V_ACTIVE,
  parameter int FRAME_SKIP          = DEF_FRAME_SKIP,
  parameter bit BYTE_ORDER_HI_FIRST = 1'b1
) (
  input  logic        p_clk,
  input  logic        sysrst_n,
  input  logic        cmos_config_done,
  input  logic        cmos_vsync,
  input  logic        cmos_href,
  input  logic [7:0]  cmos_data,
  output logic [15:0] pixel_data,
  output logic        pixel_valid,
  output logic        cmos_frame_done,
  output logic        frame_error,
  output logic [7:0]  frame_count
);

  localparam int PIX_W  = $clog2(H_ACTIVE + 1);
  localparam int SKIP_W = (FRAME_SKIP < 1) ? 1 : $clog2(FRAME_SKIP + 1);

  localparam logic [PIX_W-1:0]      H_PIXELS  = PIX_W'(H_ACTIVE);
  localparam logic [LINE_CNT_W-1:0] V_LINES   = LINE_CNT_W'(V_ACTIVE);
  localparam logic [LINE_CNT_W-1:0] LINE_MAX  = '1;
  localparam logic [SKIP_W-1:0]     SKIP_LAST = SKIP_W'((FRAME_SKIP == 0) ? 0 : FRAME_SKIP - 1);

  logic v_q, h_q, v_rise, v_fall, h_fall;
  logic [7:0] d_q;

  cap_state_t              state;
  logic [SKIP_W-1:0]       skip_cnt;
  logic [PIX_W-1:0]        pix_cnt;
  logic [LINE_CNT_W-1:0]   line_cnt;
  logic [LINE_CNT_W-1:0]   line_next;
  logic                    byte_phase;
  logic [7:0]              first_byte;

  cmos_edge_sync u_edge_sync (
    .p_clk     (p_clk),
    .sysrst_n  (sysrst_n),
    .cmos_vsync(cmos_vsync),
    .cmos_href (cmos_href),
    .v_q       (v_q),
    .h_q       (h_q),
    .v_rise    (v_rise),
    .v_fall    (v_fall),
    .h_fall    (h_fall)
  );

  always_ff @(posedge p_clk or negedge sysrst_n) begin
    if (!sysrst_n) begin
      d_q <= 8'h00;
    end else begin
      d_q <= cmos_data;
    end
  end

  // Line count including a line ending this cycle, so a frame end that
  // coincides with the last href fall is checked against the full count.
  always_comb begin
    line_next = line_cnt;
    if (h_fall && (line_cnt != LINE_MAX)) begin
      line_next = line_cnt + 1'b1;
    end
  end

  // pixel_valid is a one-cycle strobe with no backpressure: the consumer
  // must take pixel_data in the cycle pixel_valid is high.
  always_ff @(posedge p_clk or negedge sysrst_n) begin
    if (!sysrst_n) begin
      state           <= IDLE;
      skip_cnt        <= '0;
      pix_cnt         <= '0;
      line_cnt        <= '0;
      byte_phase      <= 1'b0;
      first_byte      <= 8'h00;
      pixel_data      <= 16'h0000;
      pixel_valid     <= 1'b0;
      cmos_frame_done <= 1'b1;
      frame_error     <= 1'b0;
      frame_count     <= 8'h00;
    end else begin
      pixel_valid <= 1'b0;
      if (!cmos_config_done) begin
        state           <= IDLE;
        cmos_frame_done <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            skip_cnt <= '0;
            state    <= (FRAME_SKIP == 0) ? WAIT_FRAME : SKIP;
          end
          SKIP: begin
            if (v_rise) begin
              skip_cnt <= skip_cnt + 1'b1;
              if (skip_cnt == SKIP_LAST) begin
                state <= WAIT_FRAME;
              end
            end
          end
          WAIT_FRAME: begin
            if (v_fall) begin
              state           <= CAPTURE;
              cmos_frame_done <= 1'b0;
              frame_error     <= 1'b0;
              line_cnt        <= '0;
              pix_cnt         <= '0;
              byte_phase      <= 1'b0;
            end
          end
          CAPTURE: begin
            // href during vertical blanking carries no picture data.
            if (h_q && !v_q) begin
              byte_phase <= ~byte_phase;
              if (!byte_phase) begin
                first_byte <= d_q;
              end else if ((pix_cnt < H_PIXELS) && (line_cnt < V_LINES)) begin
                pixel_data  <= pack_pixel(first_byte, d_q, BYTE_ORDER_HI_FIRST);
                pixel_valid <= 1'b1;
                pix_cnt     <= pix_cnt + 1'b1;
              end else begin
                frame_error <= 1'b1;
              end
            end
            if (h_fall) begin
              line_cnt   <= line_next;
              pix_cnt    <= '0;
              byte_phase <= 1'b0;
              if (byte_phase || (pix_cnt != H_PIXELS)) begin
                frame_error <= 1'b1;
              end
            end
            if (v_rise) begin
              state           <= WAIT_FRAME;
              cmos_frame_done <= 1'b1;
              frame_count     <= frame_count + 1'b1;
              if (line_next != V_LINES) begin
                frame_error <= 1'b1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cmos_capture.sv
// Random-data bench for cmos_capture: two instances (skip 2 / hi-first and
// skip 0 / lo-first) share one sensor bus and are checked against an
// event-level frame model and an expected-pixel queue per instance.
module tb_cmos_capture;

  localparam int H = 4;
  localparam int V = 3;

  logic        p_clk = 1'b0;
  logic        sysrst_n = 1'b1;
  logic        cfg = 1'b0;
  logic        vs = 1'b1;
  logic        hr = 1'b0;
  logic [7:0]  dat = 8'h00;

  logic [15:0] pd_a, pd_b;
  logic        pv_a, pv_b, fd_a, fd_b, fe_a, fe_b;
  logic [7:0]  fc_a, fc_b;

  cmos_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .FRAME_SKIP(2), .BYTE_ORDER_HI_FIRST(1'b1)) dut_a (
    .p_clk(p_clk), .sysrst_n(sysrst_n), .cmos_config_done(cfg), .cmos_vsync(vs),
    .cmos_href(hr), .cmos_data(dat), .pixel_data(pd_a), .pixel_valid(pv_a),
    .cmos_frame_done(fd_a), .frame_error(fe_a), .frame_count(fc_a));

  cmos_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .FRAME_SKIP(0), .BYTE_ORDER_HI_FIRST(1'b0)) dut_b (
    .p_clk(p_clk), .sysrst_n(sysrst_n), .cmos_config_done(cfg), .cmos_vsync(vs),
    .cmos_href(hr), .cmos_data(dat), .pixel_data(pd_b), .pixel_valid(pv_b),
    .cmos_frame_done(fd_b), .frame_error(fe_b), .frame_count(fc_b));

  // Clock / cycle counter
  always #5 p_clk = ~p_clk;
  int cyc = 0;
  always @(posedge p_clk) cyc <= cyc + 1;

  // Scoreboard state
  int n_vec = 0;
  int n_err = 0;
  logic [47:0] exp_q_a[$];
  logic [47:0] exp_q_b[$];

  // Frame model: mode 0 = not configured, 1 = waiting/skipping, 2 = capturing
  int   m_mode[2];
  int   m_need[2];
  int   m_cnt[2];
  int   m_line[2];
  bit   m_err[2];
  int   p_skip[2] = '{2, 0};
  bit   p_hi[2]   = '{1'b1, 1'b0};

  logic [7:0] b_first;
  logic [7:0] seq_b;
  bit         use_seq;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge p_clk);
    #1;
  endtask

  // Pixel monitors
  always @(negedge p_clk) begin
    logic [47:0] e;
    if (pv_a) begin
      if (exp_q_a.size() == 0) check_eq("a_stray_strobe", 32'd1, 32'd0);
      else begin
        e = exp_q_a.pop_front();
        check_eq("a_pixel", {16'h0, pd_a}, {16'h0, e[15:0]});
        check_eq("a_strobe_cyc", cyc, e[47:16]);
      end
    end
    if (pv_b) begin
      if (exp_q_b.size() == 0) check_eq("b_stray_strobe", 32'd1, 32'd0);
      else begin
        e = exp_q_b.pop_front();
        check_eq("b_pixel", {16'h0, pd_b}, {16'h0, e[15:0]});
        check_eq("b_strobe_cyc", cyc, e[47:16]);
      end
    end
  end

  task automatic arm_model();
    for (int d = 0; d < 2; d++) begin
      m_mode[d] = 1;
      m_need[d] = p_skip[d];
    end
  endtask

  task automatic push_px(input int d, input logic [7:0] b0, input logic [7:0] b1);
    logic [15:0] px;
    logic [47:0] e;
    px = p_hi[d] ? {b0, b1} : {b1, b0};
    e  = {32'(cyc + 2), px};
    if (d == 0) exp_q_a.push_back(e);
    else        exp_q_b.push_back(e);
  endtask

  task automatic purge_after(input int c);
    logic [47:0] keep_a[$];
    logic [47:0] keep_b[$];
    foreach (exp_q_a[i]) if (int'(exp_q_a[i][47:16]) <= c) keep_a.push_back(exp_q_a[i]);
    foreach (exp_q_b[i]) if (int'(exp_q_b[i][47:16]) <= c) keep_b.push_back(exp_q_b[i]);
    exp_q_a = keep_a;
    exp_q_b = keep_b;
  endtask

  task automatic check_frame_state(input string sfx);
    check_eq({"fd_a_", sfx}, {31'h0, fd_a}, {31'h0, m_mode[0] != 2});
    check_eq({"fd_b_", sfx}, {31'h0, fd_b}, {31'h0, m_mode[1] != 2});
    check_eq({"fe_a_", sfx}, {31'h0, fe_a}, {31'h0, m_err[0]});
    check_eq({"fe_b_", sfx}, {31'h0, fe_b}, {31'h0, m_err[1]});
    check_eq({"fc_a_", sfx}, {24'h0, fc_a}, m_cnt[0] & 255);
    check_eq({"fc_b_", sfx}, {24'h0, fc_b}, m_cnt[1] & 255);
  endtask

  task automatic vsync_set(input logic v);
    bit old_fd[2];
    for (int d = 0; d < 2; d++) old_fd[d] = (m_mode[d] != 2);
    vs = v;
    for (int d = 0; d < 2; d++) begin
      if (v) begin
        if (m_mode[d] == 2) begin
          if (m_line[d] != V) m_err[d] = 1'b1;
          m_cnt[d]++;
          m_mode[d] = 1;
          m_need[d] = 0;
        end else if (m_mode[d] == 1 && m_need[d] > 0) begin
          m_need[d]--;
        end
      end else if (m_mode[d] == 1 && m_need[d] == 0) begin
        m_mode[d] = 2;
        m_err[d]  = 1'b0;
        m_line[d] = 0;
      end
    end
    tick();
    check_eq("fd_a_edge_plus1", {31'h0, fd_a}, {31'h0, old_fd[0]});
    check_eq("fd_b_edge_plus1", {31'h0, fd_b}, {31'h0, old_fd[1]});
    tick();
    check_frame_state(v ? "vrise" : "vfall");
    tick();
    tick();
  endtask

  task automatic drive_byte(input int k);
    logic [7:0] b;
    b = use_seq ? seq_b : 8'($urandom_range(0, 255));
    if (use_seq) seq_b++;
    hr  = 1'b1;
    dat = b;
    if (k % 2 == 0) b_first = b;
    else begin
      for (int d = 0; d < 2; d++) begin
        if (m_mode[d] == 2) begin
          if (m_line[d] < V && k / 2 < H) push_px(d, b_first, b);
          else m_err[d] = 1'b1;
        end
      end
    end
    tick();
  endtask

  task automatic drive_line(input int nbytes, input bit end_with_vsync);
    for (int k = 0; k < nbytes; k++) drive_byte(k);
    for (int d = 0; d < 2; d++) begin
      if (m_mode[d] == 2) begin
        if (nbytes % 2 != 0 || nbytes / 2 != H) m_err[d] = 1'b1;
        m_line[d]++;
      end
    end
    hr  = 1'b0;
    dat = 8'h00;
    if (end_with_vsync) vsync_set(1'b1);
    else begin
      tick();
      tick();
      check_eq("fe_a_line_end", {31'h0, fe_a}, {31'h0, m_err[0]});
      check_eq("fe_b_line_end", {31'h0, fe_b}, {31'h0, m_err[1]});
      tick();
      tick();
    end
  endtask

  task automatic drive_frame(input int nlines, input int odd_line, input bit simul_end,
                             input bit href_in_vs);
    vsync_set(1'b0);
    tick();
    for (int l = 0; l < nlines; l++)
      drive_line((l == odd_line) ? 7 : 2 * H, simul_end && (l == nlines - 1));
    if (!simul_end) vsync_set(1'b1);
    if (href_in_vs) begin
      for (int k = 0; k < 4; k++) drive_byte(k);
      hr = 1'b0;
      repeat (3) tick();
    end
  endtask

  task automatic check_reset_outputs(input string sfx);
    check_eq({"pd_a_", sfx}, {16'h0, pd_a}, 32'h0);
    check_eq({"pv_a_", sfx}, {31'h0, pv_a}, 32'h0);
    check_eq({"fd_a_", sfx}, {31'h0, fd_a}, 32'h1);
    check_eq({"fe_a_", sfx}, {31'h0, fe_a}, 32'h0);
    check_eq({"fc_a_", sfx}, {24'h0, fc_a}, 32'h0);
    check_eq({"pd_b_", sfx}, {16'h0, pd_b}, 32'h0);
    check_eq({"pv_b_", sfx}, {31'h0, pv_b}, 32'h0);
    check_eq({"fd_b_", sfx}, {31'h0, fd_b}, 32'h1);
    check_eq({"fe_b_", sfx}, {31'h0, fe_b}, 32'h0);
    check_eq({"fc_b_", sfx}, {24'h0, fc_b}, 32'h0);
  endtask

  initial begin
    int c;
    for (int d = 0; d < 2; d++) begin
      m_mode[d] = 0; m_need[d] = 0; m_cnt[d] = 0; m_line[d] = 0; m_err[d] = 1'b0;
    end
    use_seq = 1'b0;
    seq_b   = 8'h01;
    b_first = 8'h00;

    // Power-on reset
    #2 sysrst_n = 1'b0;
    #1 check_reset_outputs("por");
    repeat (3) tick();
    sysrst_n = 1'b1;
    repeat (3) tick();

    // Configure, then four clean frames of bytes 0x01..0x18
    cfg = 1'b1;
    arm_model();
    repeat (4) tick();
    use_seq = 1'b1;
    for (int f = 0; f < 4; f++) begin
      seq_b = 8'h01;
      drive_frame(V, -1, f == 3, f == 3);
    end
    use_seq = 1'b0;

    // Geometry faults, each followed by a clean frame that clears the error
    drive_frame(V, 1, 1'b0, 1'b0);
    drive_frame(V, -1, 1'b0, 1'b0);
    drive_frame(2, -1, 1'b0, 1'b0);
    drive_frame(V, -1, 1'b0, 1'b0);
    drive_frame(4, -1, 1'b0, 1'b0);
    drive_frame(V, -1, 1'b1, 1'b0);

    // Config drop mid-line
    vsync_set(1'b0);
    tick();
    for (int k = 0; k < 3; k++) drive_byte(k);
    cfg = 1'b0;
    dat = 8'($urandom_range(0, 255));
    c = cyc;
    for (int d = 0; d < 2; d++) m_mode[d] = 0;
    purge_after(c);
    tick();
    check_eq("pv_a_cfg_drop", {31'h0, pv_a}, 32'h0);
    check_eq("pv_b_cfg_drop", {31'h0, pv_b}, 32'h0);
    check_eq("fd_a_cfg_drop", {31'h0, fd_a}, 32'h1);
    check_eq("fd_b_cfg_drop", {31'h0, fd_b}, 32'h1);
    check_eq("fc_a_cfg_drop", {24'h0, fc_a}, m_cnt[0] & 255);
    check_eq("fc_b_cfg_drop", {24'h0, fc_b}, m_cnt[1] & 255);
    hr = 1'b0;
    repeat (3) tick();
    vsync_set(1'b1);
    cfg = 1'b1;
    arm_model();
    repeat (3) tick();
    for (int f = 0; f < 3; f++) drive_frame(V, -1, 1'b0, 1'b0);

    // Asynchronous reset mid-frame
    vsync_set(1'b0);
    tick();
    for (int k = 0; k < 3; k++) drive_byte(k);
    sysrst_n = 1'b0;
    #1 check_reset_outputs("mid_frame_rst");
    exp_q_a.delete();
    exp_q_b.delete();
    for (int d = 0; d < 2; d++) begin
      m_mode[d] = 0; m_cnt[d] = 0; m_err[d] = 1'b0; m_line[d] = 0;
    end
    hr  = 1'b0;
    dat = 8'h00;
    repeat (2) tick();
    sysrst_n = 1'b1;
    arm_model();
    repeat (3) tick();
    vsync_set(1'b1);
    for (int f = 0; f < 2; f++) drive_frame(V, -1, 1'b0, 1'b0);
    repeat (4) tick();

    check_eq("a_pending_pixels", exp_q_a.size(), 32'd0);
    check_eq("b_pending_pixels", exp_q_b.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
